// File: rtl/ceyloniac_pc_src_gen.sv
// ceyloniac_pc_src_gen
//   Builds the four candidate PCs and the 2-bit select for the fetch PC mux.
//   Also holds the architectural fetch PC register.
//   Redirect priority is exception > branch > jump > sequential.
//   A redirect that arrives while the pipeline is stalled is held until the
//   stall releases. Each redirect produces a one-cycle flush pulse.
//
// Build option
//   CEYLONIAC_DELAY_SLOT_EN - branches and jumps execute one delay slot before
//   redirecting, and do not flush. Exceptions still redirect immediately, with
//   a flush, and cancel any pending redirect.
//
// Ports
//   clk, reset_n     rising-edge clock, synchronous active-low reset
//   stall            hazard-unit stall; the PC does not advance
//   branch_taken     EX-stage branch resolved taken, with branch_target
//   jump             jump decoded, with jump_target
//   exception        exception raised
//   pc               registered fetch PC
//   pc_in_0..3       mux candidates: pc+PC_STEP, branch, jump, EXC_VECTOR
//   pc_src           mux select: 00 seq, 01 branch, 10 jump, 11 exception
//   flush            registered one-cycle squash of younger stages
//   fetch_valid      pc is a valid fetch address this cycle
//   state_dbg        FSM state: 0 BOOT, 1 RUN, 2 HOLD
//
// Handshake note: there is no valid/ready pair. Requests are level-sampled on
// every rising edge. A stalled request must stay asserted until the edge that
// captures it (the RUN edge with stall=1). After that edge the block keeps its
// own copy, so the request may drop.
module ceyloniac_pc_src_gen #(
    parameter int                        ALU_DATA_WIDTH = 32,
    parameter logic [ALU_DATA_WIDTH-1:0] RESET_VECTOR   = 32'h0000_0000,
    parameter logic [ALU_DATA_WIDTH-1:0] EXC_VECTOR     = 32'h0000_0080,
    parameter int                        PC_STEP        = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      stall,
    input  logic                      branch_taken,
    input  logic [ALU_DATA_WIDTH-1:0] branch_target,
    input  logic                      jump,
    input  logic [ALU_DATA_WIDTH-1:0] jump_target,
    input  logic                      exception,
    output logic [ALU_DATA_WIDTH-1:0] pc,
    output logic [ALU_DATA_WIDTH-1:0] pc_in_0,
    output logic [ALU_DATA_WIDTH-1:0] pc_in_1,
    output logic [ALU_DATA_WIDTH-1:0] pc_in_2,
    output logic [ALU_DATA_WIDTH-1:0] pc_in_3,
    output logic [1:0]                pc_src,
    output logic                      flush,
    output logic                      fetch_valid,
    output logic [1:0]                state_dbg
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] SRC_SEQ = 2'b00;
    localparam logic [1:0] SRC_BR  = 2'b01;
    localparam logic [1:0] SRC_JMP = 2'b10;
    localparam logic [1:0] SRC_EXC = 2'b11;

    state_t                    state_q, state_d;
    logic [ALU_DATA_WIDTH-1:0] pc_q;
    logic                      flush_q;
    logic [1:0]                held_src_q;
    logic [ALU_DATA_WIDTH-1:0] held_tgt_q;

    logic [1:0]                live_src;   // priority-encoded live request
    logic [1:0]                req_src;    // effective request (live or held)
    logic [ALU_DATA_WIDTH-1:0] req_tgt;
    logic                      capture;    // request worth holding across a stall
    logic                      advance;    // PC register loads this edge
    logic                      capture_en; // held registers load this edge
    logic                      flush_d;
    logic [ALU_DATA_WIDTH-1:0] pc_next;

`ifdef CEYLONIAC_DELAY_SLOT_EN
    logic                      pend_valid_q;
    logic [1:0]                pend_src_q;
    logic [ALU_DATA_WIDTH-1:0] pend_tgt_q;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_BOOT;
        else          state_q <= state_d;
    end

    // ---------------- request resolution ----------------
    always_comb begin
        live_src = SRC_SEQ;
        if (exception)         live_src = SRC_EXC;
        else if (branch_taken) live_src = SRC_BR;
        else if (jump)         live_src = SRC_JMP;

        req_src = SRC_SEQ;
        req_tgt = branch_target;
        case (state_q)
            ST_RUN: begin
                req_src = live_src;
                req_tgt = (live_src == SRC_BR) ? branch_target : jump_target;
            end
            ST_HOLD: begin
                // Only a new exception can displace the held redirect.
                req_src = exception ? SRC_EXC : held_src_q;
                req_tgt = held_tgt_q;
            end
            default: ;
        endcase

`ifdef CEYLONIAC_DELAY_SLOT_EN
        // While a delayed redirect is pending, only an exception can replace it.
        capture = (req_src == SRC_EXC) || ((req_src != SRC_SEQ) && !pend_valid_q);
`else
        capture = (req_src != SRC_SEQ);
`endif
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (stall && capture) state_d = ST_HOLD;
            ST_HOLD: if (!stall) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        fetch_valid = (state_q == ST_RUN);
        advance     = !stall && ((state_q == ST_RUN) || (state_q == ST_HOLD));
        capture_en  = stall && (((state_q == ST_RUN) && capture) ||
                                ((state_q == ST_HOLD) && exception));

        pc_in_0 = pc_q + ALU_DATA_WIDTH'(PC_STEP);
        pc_in_3 = EXC_VECTOR;
        pc_in_1 = (state_q == ST_HOLD) ? held_tgt_q : branch_target;
        pc_in_2 = (state_q == ST_HOLD) ? held_tgt_q : jump_target;

`ifdef CEYLONIAC_DELAY_SLOT_EN
        if (pend_valid_q) begin
            pc_in_1 = pend_tgt_q;
            pc_in_2 = pend_tgt_q;
        end
        // A fresh branch/jump fetches its delay slot first (select 00). The
        // target is selected one advancing edge later, from the pending record.
        if (state_q == ST_BOOT)       pc_src = SRC_SEQ;
        else if (req_src == SRC_EXC)  pc_src = SRC_EXC;
        else if (pend_valid_q)        pc_src = pend_src_q;
        else                          pc_src = SRC_SEQ;
        flush_d = (pc_src == SRC_EXC);
`else
        pc_src  = req_src;
        flush_d = (pc_src != SRC_SEQ);
`endif

        case (pc_src)
            SRC_BR:  pc_next = pc_in_1;
            SRC_JMP: pc_next = pc_in_2;
            SRC_EXC: pc_next = pc_in_3;
            default: pc_next = pc_in_0;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q       <= RESET_VECTOR;
            flush_q    <= 1'b0;
            held_src_q <= SRC_SEQ;
            held_tgt_q <= '0;
        end else begin
            flush_q <= 1'b0;
            if (advance) begin
                pc_q    <= pc_next;
                flush_q <= flush_d;
            end
            if (capture_en) begin
                held_src_q <= req_src;
                held_tgt_q <= req_tgt;
            end else if ((state_q == ST_HOLD) && !stall) begin
                held_src_q <= SRC_SEQ;
                held_tgt_q <= '0;
            end
        end
    end

`ifdef CEYLONIAC_DELAY_SLOT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_valid_q <= 1'b0;
            pend_src_q   <= SRC_SEQ;
            pend_tgt_q   <= '0;
        end else if (advance) begin
            if (pc_src == SRC_EXC || pend_valid_q) begin
                pend_valid_q <= 1'b0;
            end else if (req_src == SRC_BR || req_src == SRC_JMP) begin
                pend_valid_q <= 1'b1;
                pend_src_q   <= req_src;
                pend_tgt_q   <= req_tgt;
            end
        end
    end
`endif

    assign pc        = pc_q;
    assign flush     = flush_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ceyloniac_pc_src_gen.sv
module tb_ceyloniac_pc_src_gen;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         stall, branch_taken, jump, exception;
    logic [W-1:0] branch_target, jump_target;
    logic [W-1:0] pc, pc_in_0, pc_in_1, pc_in_2, pc_in_3;
    logic [1:0]   pc_src, state_dbg;
    logic         flush, fetch_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [1:0] BOOT = 2'd0, RUN = 2'd1, HOLD = 2'd2;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    ceyloniac_pc_src_gen dut (
        .clk(clk), .reset_n(reset_n), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .exception(exception),
        .pc(pc), .pc_in_0(pc_in_0), .pc_in_1(pc_in_1), .pc_in_2(pc_in_2),
        .pc_in_3(pc_in_3), .pc_src(pc_src), .flush(flush),
        .fetch_valid(fetch_valid), .state_dbg(state_dbg)
    );

    // One row = inputs driven for one cycle plus the outputs expected in that
    // cycle (before the next rising edge).
    typedef struct {
        logic         stall, br;
        logic [W-1:0] bt;
        logic         jmp;
        logic [W-1:0] jt;
        logic         exc;
        logic [W-1:0] pc;
        logic [1:0]   src;
        logic         flush, fv;
        logic [1:0]   st;
    } vec_t;

    vec_t tbl[$];

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge. Outputs are checked
    // 2 time units after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic b, input logic [W-1:0] bt_v,
                         input logic j, input logic [W-1:0] jt_v, input logic e);
        stall = s; branch_taken = b; branch_target = bt_v;
        jump = j; jump_target = jt_v; exception = e;
    endtask

    task automatic add(input logic s, input logic b, input logic [W-1:0] bt_v,
                       input logic j, input logic [W-1:0] jt_v, input logic e,
                       input logic [W-1:0] epc, input logic [1:0] esrc,
                       input logic efl, input logic efv, input logic [1:0] est);
        vec_t v;
        v.stall = s; v.br = b; v.bt = bt_v; v.jmp = j; v.jt = jt_v; v.exc = e;
        v.pc = epc; v.src = esrc; v.flush = efl; v.fv = efv; v.st = est;
        tbl.push_back(v);
    endtask

    task automatic check_row(input int i, input vec_t v);
        string tag;
        tag = $sformatf("row%0d", i);
        chk({tag, ".pc"},          pc,                 v.pc);
        chk({tag, ".pc_src"},      W'(pc_src),         W'(v.src));
        chk({tag, ".flush"},       W'(flush),          W'(v.flush));
        chk({tag, ".fetch_valid"}, W'(fetch_valid),    W'(v.fv));
        chk({tag, ".state"},       W'(state_dbg),      W'(v.st));
        chk({tag, ".pc_in_0"},     pc_in_0,            v.pc + 32'd4);
        chk({tag, ".pc_in_3"},     pc_in_3,            32'h80);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        do_reset();

`ifdef CEYLONIAC_DELAY_SLOT_EN
        //   stall br bt       jmp jt  exc  pc         src   fl fv st
        add(0, 0, 0,       0, 0, 0, 32'h00, 2'b00, 0, 0, BOOT);
        add(0, 0, 0,       0, 0, 0, 32'h00, 2'b00, 0, 1, RUN);
        add(0, 0, 0,       0, 0, 0, 32'h04, 2'b00, 0, 1, RUN);
        add(0, 0, 0,       0, 0, 0, 32'h08, 2'b00, 0, 1, RUN);
        add(0, 0, 0,       0, 0, 0, 32'h0C, 2'b00, 0, 1, RUN);
        add(0, 1, 32'h40,  0, 0, 0, 32'h10, 2'b00, 0, 1, RUN);  // delay slot next
        add(0, 0, 0,       0, 0, 0, 32'h14, 2'b01, 0, 1, RUN);  // target selected
        add(0, 0, 0,       0, 0, 0, 32'h40, 2'b00, 0, 1, RUN);  // no flush
        add(0, 0, 0,       0, 0, 0, 32'h44, 2'b00, 0, 1, RUN);
`else
        // reset release, sequential fetch
        add(0, 0, 0,       0, 0,  0, 32'h00, 2'b00, 0, 0, BOOT);
        add(0, 0, 0,       0, 0,  0, 32'h00, 2'b00, 0, 1, RUN);
        add(0, 0, 0,       0, 0,  0, 32'h04, 2'b00, 0, 1, RUN);
        add(0, 0, 0,       0, 0,  0, 32'h08, 2'b00, 0, 1, RUN);
        add(0, 0, 0,       0, 0,  0, 32'h0C, 2'b00, 0, 1, RUN);
        // taken branch at 0x10
        add(0, 1, 32'h40,  0, 0,  0, 32'h10, 2'b01, 0, 1, RUN);
        add(0, 0, 0,       0, 0,  0, 32'h40, 2'b00, 1, 1, RUN);
        // jump to 0x20, then stalled jump to 0x100 (stall for 3 cycles)
        add(0, 0, 0,       1, 32'h20, 0, 32'h44, 2'b10, 0, 1, RUN);
        add(1, 0, 0,       1, 32'h100, 0, 32'h20, 2'b10, 1, 1, RUN);
        add(1, 0, 0,       0, 0,  0, 32'h20, 2'b10, 0, 0, HOLD);
        add(1, 1, 32'h999, 0, 0,  0, 32'h20, 2'b10, 0, 0, HOLD); // lower priority ignored
        add(0, 0, 0,       0, 0,  0, 32'h20, 2'b10, 0, 0, HOLD); // release
        // all three requests at once: exception wins
        add(0, 1, 32'h44,  1, 32'h55, 1, 32'h100, 2'b11, 1, 1, RUN);
        // branch + jump: branch wins
        add(0, 1, 32'h200, 1, 32'h300, 0, 32'h80, 2'b01, 1, 1, RUN);
        add(0, 0, 0,       0, 0,  0, 32'h200, 2'b00, 1, 1, RUN);
        // wrap from the top of the address space
        add(0, 0, 0,       1, 32'hFFFF_FFFC, 0, 32'h204, 2'b10, 0, 1, RUN);
        add(0, 0, 0,       0, 0,  0, 32'hFFFF_FFFC, 2'b00, 1, 1, RUN);
        add(0, 0, 0,       0, 0,  0, 32'h0, 2'b00, 0, 1, RUN);
        // exception overrides a held branch and stays held after it drops
        add(1, 1, 32'h40,  0, 0,  0, 32'h4, 2'b01, 0, 1, RUN);
        add(1, 0, 0,       0, 0,  1, 32'h4, 2'b11, 0, 0, HOLD);
        add(0, 0, 0,       0, 0,  0, 32'h4, 2'b11, 0, 0, HOLD);
        add(0, 0, 0,       0, 0,  0, 32'h80, 2'b00, 1, 1, RUN);
        add(0, 0, 0,       0, 0,  0, 32'h84, 2'b00, 0, 1, RUN);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].stall, tbl[i].br, tbl[i].bt, tbl[i].jmp, tbl[i].jt, tbl[i].exc);
            #1;
            check_row(i, tbl[i]);
            next_cycle();
        end

`ifndef CEYLONIAC_DELAY_SLOT_EN
        // Held target stays visible on pc_in_2 after the live target changes.
        drive(1, 0, 0, 1, 32'h1234, 0);   // pc = 0x88, stalled jump captured
        next_cycle();
        drive(1, 0, 32'hDEAD, 0, 32'hBEEF, 0);
        #1;
        chk("held.pc_in_2", pc_in_2, 32'h1234);
        chk("held.pc_in_1", pc_in_1, 32'h1234);
        chk("held.state",   W'(state_dbg), W'(HOLD));

        // Reset while in HOLD discards the held redirect.
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        next_cycle();
        reset_n = 1'b1;
        #1;
        chk("rst_hold.pc",    pc, 32'h0);
        chk("rst_hold.state", W'(state_dbg), W'(BOOT));
        chk("rst_hold.fv",    W'(fetch_valid), 32'd0);
        chk("rst_hold.flush", W'(flush), 32'd0);
        next_cycle();
        #1;
        chk("rst_hold.src",   W'(pc_src), 32'd0);
        chk("rst_hold.run",   W'(state_dbg), W'(RUN));
        next_cycle();
        #1;
        chk("rst_hold.seq",   pc, 32'h4);
        chk("rst_hold.noflush", W'(flush), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule

// File: doc/ceyloniac_pc_src_gen.md
Name: ceyloniac_pc_src_gen

Overview:
- Drives the 4-way PC select mux: produces pc_src and all four candidate PCs (pc_in_0..3), and holds the architectural fetch PC register.
- Resolves redirect priority among exception, branch and jump; holds a redirect that arrives during a stall; issues a one-cycle pipeline flush per redirect.
- Sits between execute-stage branch resolution, hazard unit and instruction fetch.

Parameters:
- ALU_DATA_WIDTH, 32, width of all PC/address values
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset
- EXC_VECTOR, 32'h0000_0080, exception handler address (pc_in_3)
- PC_STEP, 4, sequential increment

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- stall  input  1  hazard-unit stall; PC must not advance
- branch_taken  input  1  EX-stage branch resolved taken
- branch_target  input  ALU_DATA_WIDTH  branch destination
- jump  input  1  jump decoded
- jump_target  input  ALU_DATA_WIDTH  jump destination
- exception  input  1  exception raised
- pc  output  ALU_DATA_WIDTH  current fetch PC (registered)
- pc_in_0  output  ALU_DATA_WIDTH  pc + PC_STEP (combinational)
- pc_in_1  output  ALU_DATA_WIDTH  branch target (live or held)
- pc_in_2  output  ALU_DATA_WIDTH  jump target (live or held)
- pc_in_3  output  ALU_DATA_WIDTH  EXC_VECTOR constant
- pc_src  output  2  mux select: 00 seq, 01 branch, 10 jump, 11 exception
- flush  output  1  registered one-cycle squash of younger stages
- fetch_valid  output  1  pc is a valid fetch address this cycle

Behaviour:
- Clocking: one clock clk. Reset: reset_n, synchronous, active-low, sampled on the rising edge only.
- Reset values: pc=RESET_VECTOR, flush=0, fetch_valid=0, state=BOOT, held-redirect register cleared to 00/0.
- States:
  - BOOT: fetch_valid=0; next edge -> RUN. pc stays at RESET_VECTOR.
  - RUN: fetch_valid=1.
  - HOLD: redirect captured while stalled; fetch_valid=0.
- Request priority each cycle: exception > branch_taken > jump > sequential. The winner sets pc_src 11/01/10/00.
- RUN, stall=0: pc <= mux value selected by pc_src. flush <= 1 if pc_src != 00, else 0.
- RUN, stall=1, no request: pc holds; flush <= 0.
- RUN, stall=1, request: capture pc_src and target into the held registers; pc holds; -> HOLD.
- HOLD:
  - pc_src and pc_in_1/pc_in_2 are driven from the held registers.
  - A new exception overrides the held redirect (pc_src=11).
  - A lower-priority request is ignored.
  - On the first cycle with stall=0: pc <= held target, flush <= 1, -> RUN.
- Branch and jump asserted together: branch wins; the jump is dropped.
- Latency: pc updates on the edge after a request with stall=0. flush is high for exactly the following cycle.
- Arithmetic: pc + PC_STEP wraps modulo 2^ALU_DATA_WIDTH, with no overflow flag.
- Reset mid-HOLD: the held redirect is discarded and the block restarts in BOOT.
- pc_in_3 is constant. pc_in_0 is derived from the registered pc.

Optional Feature:
- Macro: CEYLONIAC_DELAY_SLOT_EN.
- Defined:
  - A branch or jump (not an exception) is registered as pending.
  - The next non-stalled edge fetches pc+PC_STEP (the delay slot, pc_src=00).
  - The edge after that loads the target with pc_src=01/10. flush stays 0 for branch/jump.
  - An exception still redirects immediately with flush and cancels the pending redirect.
- Undefined: immediate redirect with flush, as specified above.

Test Plan:
- Reset: reset_n=0 for 2 cycles, then release -> pc=0, fetch_valid=0 for one cycle, then pc sequence 0,4,8,C with pc_src=00 and flush=0.
- Branch: at pc=0x10, branch_taken=1, target=0x40, stall=0 -> pc_src=01, next pc=0x40, flush=1 for one cycle, then pc=0x44.
- Stalled jump: at pc=0x20, jump=1, target=0x100, stall=1 held 3 cycles -> pc holds 0x20 and state is HOLD. On stall release, pc=0x100 and flush=1.
- Simultaneous requests:
  - exception + branch_taken + jump -> pc_src=11, pc=0x80.
  - branch + jump -> pc_src=01.
- Wrap: pc=0xFFFF_FFFC, sequential -> pc=0x0000_0000.
- Reset while in HOLD -> pc=RESET_VECTOR, held redirect discarded. With CEYLONIAC_DELAY_SLOT_EN defined, a branch at 0x10 -> sequence 0x14, 0x40 with flush=0.
